sequential_sobel_xy: RTL and testbench



---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_row_weight.sv | 26 ++
 rtl/sequential_sobel_xy.sv | 181 ++++++++++++++++++
 tb/tb_sequential_sobel_xy.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the streaming 3x3 Sobel gradient engine.
//
// Contents:
//   SOBEL_MODE_Y / SOBEL_MODE_X / SOBEL_MODE_MAG : per-beat output selector codes
//                                                  (code 3 is reserved and treated as Y)
//   sobel_out_w(data_w)                          : gradient width for a given pixel width.
//                                                  Three extra bits hold the +/-4*max
//                                                  range of Gx/Gy plus sign, and the
//                                                  8*max unsigned magnitude.
package sobel_pkg;

  localparam logic [1:0] SOBEL_MODE_Y   = 2'd0;
  localparam logic [1:0] SOBEL_MODE_X   = 2'd1;
  localparam logic [1:0] SOBEL_MODE_MAG = 2'd2;

  function automatic int sobel_out_w(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/sobel_row_weight.sv
// Per-row Sobel terms for one three-pixel horizontal window (purely combinational).
//
// Ports:
//   left_i, cur_i, right_i : row pixels, DATA_W bits unsigned
//   w_o                    : L + 2C + R, DATA_W+2 bits unsigned (smoothing term, feeds Gy)
//   d_o                    : R - L, DATA_W+1 bits two's complement (difference term, feeds Gx)
module sobel_row_weight
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] left_i,
  input  logic [DATA_W-1:0] cur_i,
  input  logic [DATA_W-1:0] right_i,
  output logic [DATA_W+1:0] w_o,
  output logic [DATA_W:0]   d_o
);

  always_comb begin
    w_o = {2'b00, left_i} + {1'b0, cur_i, 1'b0} + {2'b00, right_i};
    // Zero-extend both operands one bit so the difference wraps into a
    // correct two's complement value.
    d_o = {1'b0, right_i} - {1'b0, left_i};
  end

endmodule

// File: rtl/sequential_sobel_xy.sv
// Streaming 3x3 Sobel gradient engine. Each accepted beat carries one image
// row's left/current/right pixels; the two preceding rows of the strip are
// held internally so the beat completes a 3x3 window. From the third row of
// a strip onward every beat produces one registered X gradient, Y gradient
// or L1 magnitude, chosen by that beat's mode.
//
// Build option: define SOBEL_MAG_EN to enable the magnitude mode. Without it
// mode 2 behaves as Y and out_is_mag is constant 0.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : beat qualifier; every valid beat is accepted (no backpressure)
//   sof_in      : beat is row 0 of a new strip (only meaningful with in_valid)
//   left_in, current_in, right_in : row window pixels, DATA_W bits
//   mode_in     : 0 = Y, 1 = X, 2 = magnitude, 3 = Y
//   grad_out    : OUT_W bits; two's complement for X/Y, unsigned for magnitude;
//                 holds its last value while out_valid is low
//   out_is_mag  : grad_out carries a magnitude
//   out_valid   : one-cycle pulse, one cycle after the window-completing beat
//
// Handshake: in_valid is a pure qualifier, sampled on the rising edge; the
// block has no ready. out_valid is asserted for exactly one cycle per
// qualifying beat and is never stalled.
module sequential_sobel_xy
  import sobel_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int OUT_W  = sobel_out_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              sof_in,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] current_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic [1:0]        mode_in,
  output logic [OUT_W-1:0]  grad_out,
  output logic              out_is_mag,
  output logic              out_valid
);

  localparam int W_PAD = OUT_W - DATA_W - 2;
  localparam int D_PAD = OUT_W - DATA_W - 1;

  // The incoming beat is always the bottom row, so only the two older rows
  // are stored: top_q is row r-2 and mid_q is row r-1 from the point of view
  // of the next beat. Index 0 = left, 1 = current, 2 = right.
  logic [2:0][DATA_W-1:0] top_q, top_d;
  logic [2:0][DATA_W-1:0] mid_q, mid_d;
  // Rows of the current strip held so far, saturating at 2.
  logic [1:0]             fill_q, fill_d;

  logic [OUT_W-1:0]       grad_q, grad_d;
  logic                   out_valid_q, out_valid_d;

  logic [DATA_W+1:0]      w_top, w_mid, w_bot;
  logic [DATA_W:0]        d_top, d_mid, d_bot;
  logic [OUT_W-1:0]       gx, gy, grad_sel;
  logic                   win_done;

  sobel_row_weight #(.DATA_W(DATA_W)) u_row_top (
    .left_i (top_q[0]), .cur_i (top_q[1]), .right_i (top_q[2]),
    .w_o    (w_top),    .d_o   (d_top)
  );

  sobel_row_weight #(.DATA_W(DATA_W)) u_row_mid (
    .left_i (mid_q[0]), .cur_i (mid_q[1]), .right_i (mid_q[2]),
    .w_o    (w_mid),    .d_o   (d_mid)
  );

  sobel_row_weight #(.DATA_W(DATA_W)) u_row_bot (
    .left_i (left_in),  .cur_i (current_in), .right_i (right_in),
    .w_o    (w_bot),    .d_o   (d_bot)
  );

  // Gradients are formed at full output width; the ranges (+/-4*max) fit,
  // so no saturation is needed. w_mid carries the centre row, which has a
  // zero weight in Gy.
  always_comb begin
    gy = {{W_PAD{1'b0}}, w_bot} - {{W_PAD{1'b0}}, w_top};
    gx = {{D_PAD{d_top[DATA_W]}}, d_top}
       + ({{D_PAD{d_mid[DATA_W]}}, d_mid} << 1)
       + {{D_PAD{d_bot[DATA_W]}}, d_bot};
  end

`ifdef SOBEL_MAG_EN
  logic [OUT_W-1:0] gx_abs, gy_abs, mag;
  logic             is_mag_sel;
  logic             out_is_mag_q, out_is_mag_d;

  always_comb begin
    gx_abs = gx[OUT_W-1] ? ((~gx) + OUT_W'(1)) : gx;
    gy_abs = gy[OUT_W-1] ? ((~gy) + OUT_W'(1)) : gy;
    mag    = gx_abs + gy_abs;
  end

  always_comb begin
    grad_sel   = gy;
    is_mag_sel = 1'b0;
    if (mode_in == SOBEL_MODE_X) begin
      grad_sel = gx;
    end else if (mode_in == SOBEL_MODE_MAG) begin
      grad_sel   = mag;
      is_mag_sel = 1'b1;
    end
  end
`else
  always_comb begin
    grad_sel = gy;
    if (mode_in == SOBEL_MODE_X) begin
      grad_sel = gx;
    end
  end
`endif

  // A beat completes a window only if two rows of the same strip are already
  // held; a sof beat always starts over as row 0.
  assign win_done = in_valid && !sof_in && (fill_q == 2'd2);

  always_comb begin
    top_d       = top_q;
    mid_d       = mid_q;
    fill_d      = fill_q;
    grad_d      = grad_q;
    out_valid_d = win_done;
    if (in_valid) begin
      top_d = mid_q;
      mid_d = {right_in, current_in, left_in};
      if (sof_in) begin
        fill_d = 2'd1;
      end else if (fill_q != 2'd2) begin
        fill_d = fill_q + 2'd1;
      end
    end
    if (win_done) begin
      grad_d = grad_sel;
    end
  end

`ifdef SOBEL_MAG_EN
  always_comb begin
    out_is_mag_d = out_is_mag_q;
    if (win_done) begin
      out_is_mag_d = is_mag_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_is_mag_q <= 1'b0;
    end else begin
      out_is_mag_q <= out_is_mag_d;
    end
  end

  assign out_is_mag = out_is_mag_q;
`else
  assign out_is_mag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q       <= '0;
      mid_q       <= '0;
      fill_q      <= 2'd0;
      grad_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      top_q       <= top_d;
      mid_q       <= mid_d;
      fill_q      <= fill_d;
      grad_q      <= grad_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign grad_out  = grad_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sequential_sobel_xy.sv
// Directed bench for sequential_sobel_xy (DATA_W = 8, OUT_W = 11).
// Expected gradients are hand-computed from the Sobel definitions.
module tb_sequential_sobel_xy;

`ifdef SOBEL_MAG_EN
  localparam bit MAG_EN = 1'b1;
`else
  localparam bit MAG_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        sof_in;
  logic [7:0]  left_in, current_in, right_in;
  logic [1:0]  mode_in;
  logic [10:0] grad_out;
  logic        out_is_mag;
  logic        out_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  sequential_sobel_xy #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .sof_in     (sof_in),
    .left_in    (left_in),
    .current_in (current_in),
    .right_in   (right_in),
    .mode_in    (mode_in),
    .grad_out   (grad_out),
    .out_is_mag (out_is_mag),
    .out_valid  (out_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // One beat: inputs change on the falling edge, outputs are sampled 1 time
  // unit after the accepting rising edge.
  task automatic send_beat(input logic sof, input logic [7:0] l, input logic [7:0] c,
                           input logic [7:0] r, input logic [1:0] mode);
    @(negedge clk);
    in_valid   = 1'b1;
    sof_in     = sof;
    left_in    = l;
    current_in = c;
    right_in   = r;
    mode_in    = mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sof_in   = 1'b0;
  endtask

  // An idle cycle, optionally with a stray sof_in that must be ignored.
  task automatic idle_cycle(input logic sof);
    @(negedge clk);
    in_valid   = 1'b0;
    sof_in     = sof;
    left_in    = 8'd99;
    current_in = 8'd99;
    right_in   = 8'd99;
    @(posedge clk);
    #1;
    sof_in = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; sof_in = 1'b0;
    left_in = '0; current_in = '0; right_in = '0; mode_in = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (grad_out !== 11'd0 || out_valid !== 1'b0 || out_is_mag !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: grad=%0d valid=%b mag=%b, want 0 0 0", grad_out, out_valid, out_is_mag);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs a three-row strip and checks the pulse only appears after row 3.
  task automatic run_strip(input string name, input logic [7:0] px[3][3], input logic [1:0] mode,
                           input logic [10:0] exp_grad, input logic exp_mag);
    for (int i = 0; i < 3; i++) begin
      send_beat(i == 0, px[i][0], px[i][1], px[i][2], mode);
      tests_run++;
      if (out_valid !== (i == 2)) begin
        tests_failed++;
        $display("FAIL %s valid_row%0d: got %b want %b", name, i, out_valid, (i == 2));
      end
    end
    tests_run++;
    if (grad_out !== exp_grad || out_is_mag !== exp_mag) begin
      tests_failed++;
      $display("FAIL %s value: grad=%0d mag=%b, want grad=%0d mag=%b", name, grad_out, out_is_mag, exp_grad, exp_mag);
    end
  endtask

  task automatic test_modes;
    logic [7:0] px[3][3];
    px = '{'{8'd60, 8'd82, 8'd71}, '{8'd121, 8'd174, 8'd216}, '{8'd88, 8'd127, 8'd165}};
    run_strip("mode_y", px, 2'd0, 11'd212, 1'b0);
    // Output pulse is a single cycle and the value is held afterwards.
    idle_cycle(1'b0);
    tests_run++;
    if (out_valid !== 1'b0 || grad_out !== 11'd212) begin
      tests_failed++;
      $display("FAIL y_hold: valid=%b grad=%0d, want 0 212", out_valid, grad_out);
    end
    run_strip("mode_x", px, 2'd1, 11'd278, 1'b0);
    run_strip("mode_mag", px, 2'd2, MAG_EN ? 11'd490 : 11'd212, MAG_EN);
    run_strip("mode_rsv", px, 2'd3, 11'd212, 1'b0);
  endtask

  task automatic test_extremes;
    logic [7:0] px[3][3];
    logic [10:0] e;
    px = '{'{8'd255, 8'd255, 8'd255}, '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}};
    e = -11'sd1020;
    run_strip("y_neg_max", px, 2'd0, e, 1'b0);
    px = '{'{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}, '{8'd255, 8'd255, 8'd255}};
    run_strip("y_pos_max", px, 2'd0, 11'd1020, 1'b0);
    px = '{'{8'd0, 8'd0, 8'd255}, '{8'd0, 8'd128, 8'd255}, '{8'd0, 8'd7, 8'd255}};
    run_strip("x_pos_max", px, 2'd1, 11'd1020, 1'b0);
    // Gx=+1020, Gy=+510
    px = '{'{8'd0, 8'd0, 8'd255}, '{8'd0, 8'd0, 8'd255}, '{8'd0, 8'd255, 8'd255}};
    run_strip("mag_big", px, 2'd2, MAG_EN ? 11'd1530 : 11'd510, MAG_EN);
    // Gx=-765, Gy=-765: both absolute values taken
    px = '{'{8'd255, 8'd255, 8'd0}, '{8'd255, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}};
    e = -11'sd765;
    run_strip("mag_neg", px, 2'd2, MAG_EN ? 11'd1530 : e, MAG_EN);
  endtask

  task automatic test_back_to_back;
    logic [7:0] px[3][3];
    logic [10:0] e;
    px = '{'{8'd60, 8'd82, 8'd71}, '{8'd121, 8'd174, 8'd216}, '{8'd88, 8'd127, 8'd165}};
    run_strip("b2b_first", px, 2'd0, 11'd212, 1'b0);
    // Fourth row continues the strip: Gy = 60 - 685
    send_beat(1'b0, 8'd14, 8'd15, 8'd16, 2'd0);
    e = -11'sd625;
    tests_run++;
    if (out_valid !== 1'b1 || grad_out !== e) begin
      tests_failed++;
      $display("FAIL b2b_row4: valid=%b grad=%0d, want 1 %0d", out_valid, grad_out, e);
    end
    send_beat(1'b1, 8'd1, 8'd2, 8'd3, 2'd0);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sof_restart_a: valid=%b want 0", out_valid);
    end
    send_beat(1'b0, 8'd4, 8'd5, 8'd6, 2'd0);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sof_restart_b: valid=%b want 0", out_valid);
    end
    // Mode switch to X on the completing beat: D = 2 per row -> 8
    send_beat(1'b0, 8'd7, 8'd8, 8'd9, 2'd1);
    tests_run++;
    if (out_valid !== 1'b1 || grad_out !== 11'd8) begin
      tests_failed++;
      $display("FAIL sof_restart_c: valid=%b grad=%0d, want 1 8", out_valid, grad_out);
    end
  endtask

  task automatic test_reset_mid;
    send_beat(1'b1, 8'd60, 8'd82, 8'd71, 2'd0);
    send_beat(1'b0, 8'd121, 8'd174, 8'd216, 2'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (grad_out !== 11'd0 || out_valid !== 1'b0 || out_is_mag !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: grad=%0d valid=%b mag=%b, want 0 0 0", grad_out, out_valid, out_is_mag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // No sof: first beat after reset is row 0 anyway.
    send_beat(1'b0, 8'd60, 8'd82, 8'd71, 2'd0);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_row0: valid=%b want 0", out_valid);
    end
    send_beat(1'b0, 8'd121, 8'd174, 8'd216, 2'd0);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_row1: valid=%b want 0", out_valid);
    end
    send_beat(1'b0, 8'd88, 8'd127, 8'd165, 2'd0);
    tests_run++;
    if (out_valid !== 1'b1 || grad_out !== 11'd212) begin
      tests_failed++;
      $display("FAIL reset_row2: valid=%b grad=%0d, want 1 212", out_valid, grad_out);
    end
  endtask

  task automatic test_gaps;
    int gap_valids;
    gap_valids = 0;
    send_beat(1'b1, 8'd60, 8'd82, 8'd71, 2'd1);
    idle_cycle(1'b1);
    gap_valids += out_valid;
    idle_cycle(1'b1);
    gap_valids += out_valid;
    send_beat(1'b0, 8'd121, 8'd174, 8'd216, 2'd1);
    gap_valids += out_valid;
    idle_cycle(1'b1);
    gap_valids += out_valid;
    tests_run++;
    if (gap_valids !== 0 || grad_out !== 11'd212) begin
      tests_failed++;
      $display("FAIL gap_quiet: valids=%0d grad=%0d, want 0 212", gap_valids, grad_out);
    end
    send_beat(1'b0, 8'd88, 8'd127, 8'd165, 2'd1);
    tests_run++;
    if (out_valid !== 1'b1 || grad_out !== 11'd278) begin
      tests_failed++;
      $display("FAIL gap_result: valid=%b grad=%0d, want 1 278", out_valid, grad_out);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_modes();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_gaps();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
